// File: rtl/overheat_discharge_sequencer_pkg.sv
// overheat_discharge_sequencer_pkg
// Purpose: the types and constants shared by the discharge sequencer top and its
//          per-engine channel.
//   chanState_t        channel FSM states
//   ARM_DELAY_DEF      default ARM dwell, in cycles
//   SQUIB_CYCLES_DEF   default squib firing-pulse width, in cycles
//   RECHECK_DELAY_DEF  default post-discharge observation window, in cycles
//   CNT_W              width of the channel down-counter
//   pickBottle()       one-hot select of the lowest-numbered unspent bottle
package overheat_discharge_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    SHOT      = 3'd2,
    RECHECK   = 3'd3,
    EXHAUSTED = 3'd4
  } chanState_t;

  localparam int ARM_DELAY_DEF     = 16;
  localparam int SQUIB_CYCLES_DEF  = 4;
  localparam int RECHECK_DELAY_DEF = 32;
  localparam int CNT_W             = 8;

  // Bottle A (bit0) is used first. The caller only acts on the result when at
  // least one bottle is unspent.
  function automatic logic [1:0] pickBottle(input logic [1:0] spent);
    return spent[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/overheat_discharge_sequencer_channel.sv
// discharge_channel
// Purpose: one engine's discharge sequencer: FSM, 8-bit saturating down-counter
//          and the two spent-bottle flags.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   overheat  in   overheat control for this engine
//   cancel    in   pilot discharge-cancel, level-sensitive
//   squib     out  [1:0] squib fire lines, bit0 bottle A, bit1 bottle B
//   bottles   out  [1:0] number of unspent bottles (0..2)
//   active    out  high whenever the FSM is not in IDLE
module discharge_channel
  import overheat_discharge_sequencer_pkg::*;
#(
  parameter int ARM_DELAY     = ARM_DELAY_DEF,
  parameter int SQUIB_CYCLES  = SQUIB_CYCLES_DEF,
  parameter int RECHECK_DELAY = RECHECK_DELAY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       overheat,
  input  logic       cancel,
  output logic [1:0] squib,
  output logic [1:0] bottles,
  output logic       active
);

  chanState_t       stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [1:0]       spentReg, spentNext;
  logic [1:0]       selReg, selNext;    // bottle being fired in the current SHOT
  logic             haveBottle;

  assign haveBottle = ~(spentReg[0] & spentReg[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      spentReg <= 2'b00;
      selReg   <= 2'b00;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      spentReg <= spentNext;
      selReg   <= selNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    // Saturating count: a counter at 0 stays there until a transition reloads it.
    cntNext   = (cntReg != '0) ? cntReg - 1'b1 : '0;
    spentNext = spentReg;
    selNext   = selReg;

    unique case (stateReg)
      IDLE: begin
        if (overheat && haveBottle) begin
          stateNext = ARM;
          cntNext   = CNT_W'(ARM_DELAY - 1);
        end
      end

      ARM: begin
        // Dropping overheat or a cancel beats an expiring dwell.
        if (!overheat || cancel) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cntReg == '0) begin
          stateNext = SHOT;
          cntNext   = CNT_W'(SQUIB_CYCLES - 1);
          selNext   = pickBottle(spentReg);
          spentNext = spentReg | pickBottle(spentReg);
        end
      end

      // Inputs are deliberately not looked at here: a started pulse always completes.
      SHOT: begin
        if (cntReg == '0) begin
          stateNext = RECHECK;
          cntNext   = CNT_W'(RECHECK_DELAY - 1);
        end
      end

      RECHECK: begin
        if (cancel) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cntReg == '0) begin
          if (!overheat) begin
            stateNext = IDLE;
          end else if (haveBottle) begin
            stateNext = SHOT;
            cntNext   = CNT_W'(SQUIB_CYCLES - 1);
            selNext   = pickBottle(spentReg);
            spentNext = spentReg | pickBottle(spentReg);
          end else begin
            stateNext = EXHAUSTED;
          end
        end
      end

      EXHAUSTED: begin
        if (!overheat) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // Driven straight from the state register so an asynchronous reset drops the
  // squib lines without waiting for a clock edge.
  assign squib   = (stateReg == SHOT) ? selReg : 2'b00;
  assign bottles = {1'b0, ~spentReg[0]} + {1'b0, ~spentReg[1]};
  assign active  = (stateReg != IDLE);

endmodule

// File: rtl/overheat_discharge_sequencer.sv
// overheat_discharge_sequencer
// Purpose: two independent engine fire-bottle discharge channels plus the
//          combined fire warning.
// Build option: OVERHEAT_INPUT_SYNC_EN - when defined, eng1o, eng2o, cancel1 and
//          cancel2 each pass through a two-flop synchroniser (adds 2 cycles of
//          latency); when undefined the inputs feed the channels directly.
// Ports:
//   clk                  in   system clock, rising edge
//   rst                  in   asynchronous active-high reset
//   eng1o, eng2o         in   per-engine overheat control
//   cancel1, cancel2     in   per-engine pilot discharge-cancel
//   eng1_squib           out  [1:0] engine 1 squibs (bit0 bottle A, bit1 bottle B)
//   eng2_squib           out  [1:0] engine 2 squibs
//   eng1_bottles         out  [1:0] engine 1 unspent bottle count
//   eng2_bottles         out  [1:0] engine 2 unspent bottle count
//   fire_warn            out  high while either channel is not IDLE
module overheat_discharge_sequencer
  import overheat_discharge_sequencer_pkg::*;
#(
  parameter int ARM_DELAY     = ARM_DELAY_DEF,
  parameter int SQUIB_CYCLES  = SQUIB_CYCLES_DEF,
  parameter int RECHECK_DELAY = RECHECK_DELAY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eng1o,
  input  logic       eng2o,
  input  logic       cancel1,
  input  logic       cancel2,
  output logic [1:0] eng1_squib,
  output logic [1:0] eng2_squib,
  output logic [1:0] eng1_bottles,
  output logic [1:0] eng2_bottles,
  output logic       fire_warn
);

  // Packed as {cancel2, cancel1, eng2o, eng1o}.
  logic [3:0] chanIn;
  logic       active1, active2;

`ifdef OVERHEAT_INPUT_SYNC_EN
  logic [3:0] syncMeta, syncOut;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta <= 4'b0000;
      syncOut  <= 4'b0000;
    end else begin
      syncMeta <= {cancel2, cancel1, eng2o, eng1o};
      syncOut  <= syncMeta;
    end
  end

  assign chanIn = syncOut;
`else
  assign chanIn = {cancel2, cancel1, eng2o, eng1o};
`endif

  discharge_channel #(
    .ARM_DELAY     (ARM_DELAY),
    .SQUIB_CYCLES  (SQUIB_CYCLES),
    .RECHECK_DELAY (RECHECK_DELAY)
  ) uChan1 (
    .clk      (clk),
    .rst      (rst),
    .overheat (chanIn[0]),
    .cancel   (chanIn[2]),
    .squib    (eng1_squib),
    .bottles  (eng1_bottles),
    .active   (active1)
  );

  discharge_channel #(
    .ARM_DELAY     (ARM_DELAY),
    .SQUIB_CYCLES  (SQUIB_CYCLES),
    .RECHECK_DELAY (RECHECK_DELAY)
  ) uChan2 (
    .clk      (clk),
    .rst      (rst),
    .overheat (chanIn[1]),
    .cancel   (chanIn[3]),
    .squib    (eng2_squib),
    .bottles  (eng2_bottles),
    .active   (active2)
  );

  assign fire_warn = active1 | active2;

endmodule

// File: tb/tb_overheat_discharge_sequencer.sv
// tb_overheat_discharge_sequencer
// Table-driven bench with an expectation queue. Each table row holds input
// levels, a repeat count and the outputs expected one clock edge after those
// inputs are applied. With the input synchroniser built in, every response
// arrives LAT cycles later; the queue is primed with LAT idle entries so the
// same tables apply to both builds.
module tb_overheat_discharge_sequencer;

`ifdef OVERHEAT_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       eng1o, eng2o, cancel1, cancel2;
  logic [1:0] eng1_squib, eng2_squib, eng1_bottles, eng2_bottles;
  logic       fire_warn;

  overheat_discharge_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .eng1o        (eng1o),
    .eng2o        (eng2o),
    .cancel1      (cancel1),
    .cancel2      (cancel2),
    .eng1_squib   (eng1_squib),
    .eng2_squib   (eng2_squib),
    .eng1_bottles (eng1_bottles),
    .eng2_bottles (eng2_bottles),
    .fire_warn    (fire_warn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sq1;
    logic [1:0] sq2;
    logic [1:0] b1;
    logic [1:0] b2;
    logic       fw;
  } exp_t;

  typedef struct {
    logic e1o;
    logic e2o;
    logic c1;
    logic c2;
    int   n;
    exp_t ex;
  } vec_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  function automatic exp_t mk(input logic [1:0] sq1, input logic [1:0] sq2,
                              input logic [1:0] b1, input logic [1:0] b2,
                              input logic fw);
    exp_t e;
    e.sq1 = sq1; e.sq2 = sq2; e.b1 = b1; e.b2 = b2; e.fw = fw;
    return e;
  endfunction

  function automatic exp_t idleExp();
    return mk(2'b00, 2'b00, 2'd2, 2'd2, 1'b0);
  endfunction

  function automatic exp_t sample();
    return mk(eng1_squib, eng2_squib, eng1_bottles, eng2_bottles, fire_warn);
  endfunction

  task automatic row(input logic e1o, input logic e2o, input logic c1, input logic c2,
                     input int n, input logic [1:0] sq1, input logic [1:0] sq2,
                     input logic [1:0] b1, input logic [1:0] b2, input logic fw);
    vec_t v;
    v.e1o = e1o; v.e2o = e2o; v.c1 = c1; v.c2 = c2; v.n = n;
    v.ex  = mk(sq1, sq2, b1, b2, fw);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s cyc %0d: got sq1=%b sq2=%b b1=%0d b2=%0d fw=%b, expected sq1=%b sq2=%b b1=%0d b2=%0d fw=%b",
               name, cyc, got.sq1, got.sq2, got.b1, got.b2, got.fw,
               want.sq1, want.sq2, want.b1, want.b2, want.fw);
    end
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    eng1o = 1'b0; eng2o = 1'b0; cancel1 = 1'b0; cancel2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({name, "_reset"}, sample(), idleExp());
    $display("txn %s: reset applied, outputs sq1=%b sq2=%b b1=%0d b2=%0d fw=%b",
             name, eng1_squib, eng2_squib, eng1_bottles, eng2_bottles, fire_warn);
    rst = 1'b0;
    cyc = 0;
    sbq.delete();
    for (int i = 0; i < LAT; i++) sbq.push_back(idleExp());
  endtask

  task automatic runTable(input string name);
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        eng1o = tbl[i].e1o; eng2o = tbl[i].e2o;
        cancel1 = tbl[i].c1; cancel2 = tbl[i].c2;
        sbq.push_back(tbl[i].ex);
        @(posedge clk); #1;
        cyc++;
        if (sbq.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL %s cyc %0d: expectation queue empty", name, cyc);
        end else begin
          e = sbq.pop_front();
          check($sformatf("%s_row%0d", name, i), sample(), e);
        end
      end
      $display("txn %s row %0d: e1o=%b e2o=%b c1=%b c2=%b x%0d -> sq1=%b sq2=%b b1=%0d b2=%0d fw=%b",
               name, i, tbl[i].e1o, tbl[i].e2o, tbl[i].c1, tbl[i].c2, tbl[i].n,
               eng1_squib, eng2_squib, eng1_bottles, eng2_bottles, fire_warn);
    end
    tbl.delete();
    sbq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Hold eng1o: squib A for cycles 17-20, one bottle left from cycle 17.
    doReset("hold1");
    row(1,0,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,0,0,0, 4, 2'b01,2'b00,2'd1,2'd2,1);
    row(1,0,0,0, 8, 2'b00,2'b00,2'd1,2'd2,1);
    runTable("hold1");

    // Short overheat pulse: back to IDLE at cycle 11, no discharge.
    doReset("pulse1");
    row(1,0,0,0,10, 2'b00,2'b00,2'd2,2'd2,1);
    row(0,0,0,0,10, 2'b00,2'b00,2'd2,2'd2,0);
    runTable("pulse1");

    // Engine 2 held: both bottles fire, then EXHAUSTED; rearming is refused.
    doReset("exhaust2");
    row(0,1,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(0,1,0,0, 4, 2'b00,2'b01,2'd2,2'd1,1);
    row(0,1,0,0,32, 2'b00,2'b00,2'd2,2'd1,1);
    row(0,1,0,0, 4, 2'b00,2'b10,2'd2,2'd0,1);
    row(0,1,0,0,32, 2'b00,2'b00,2'd2,2'd0,1);
    row(0,1,0,0, 5, 2'b00,2'b00,2'd2,2'd0,1);
    row(0,0,0,0, 3, 2'b00,2'b00,2'd2,2'd0,0);
    row(0,1,0,0,40, 2'b00,2'b00,2'd2,2'd0,0);
    runTable("exhaust2");

    // Cancel during ARM: IDLE at cycle 11, rearm, full dwell again.
    doReset("cancelArm");
    row(1,0,0,0,10, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,0,1,0, 1, 2'b00,2'b00,2'd2,2'd2,0);
    row(1,0,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,0,0,0, 4, 2'b01,2'b00,2'd1,2'd2,1);
    runTable("cancelArm");

    // Cancel during SHOT is ignored; cancel during RECHECK returns to IDLE.
    doReset("cancelShot");
    row(1,0,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,0,0,0, 1, 2'b01,2'b00,2'd1,2'd2,1);
    row(1,0,1,0, 3, 2'b01,2'b00,2'd1,2'd2,1);
    row(1,0,0,0, 1, 2'b00,2'b00,2'd1,2'd2,1);
    row(1,0,1,0, 1, 2'b00,2'b00,2'd1,2'd2,0);
    row(1,0,0,0, 3, 2'b00,2'b00,2'd1,2'd2,1);
    runTable("cancelShot");

    // Cancel on the cycle the ARM counter expires: IDLE wins over SHOT.
    doReset("armTie");
    row(1,0,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,0,1,0, 1, 2'b00,2'b00,2'd2,2'd2,0);
    row(1,0,0,0, 1, 2'b00,2'b00,2'd2,2'd2,1);
    runTable("armTie");

    // Both engines together fire on identical cycles; reset mid-SHOT.
    doReset("both");
    row(1,1,0,0,16, 2'b00,2'b00,2'd2,2'd2,1);
    row(1,1,0,0, 2, 2'b01,2'b01,2'd1,2'd1,1);
    runTable("both");
    // Now part way into cycle 18: reset must clear the squibs with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("asyncRst", sample(), idleExp());
    $display("txn asyncRst: sq1=%b sq2=%b b1=%0d b2=%0d fw=%b",
             eng1_squib, eng2_squib, eng1_bottles, eng2_bottles, fire_warn);
    @(posedge clk); #1;
    check("rstHeld", sample(), idleExp());
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      check("syncWait", sample(), idleExp());
    end
    @(posedge clk); #1;
    check("firstEdge", sample(), mk(2'b00,2'b00,2'd2,2'd2,1'b1));
    $display("txn firstEdge: fw=%b after first edge following reset release", fire_warn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
